// File: rtl/fs_accel_pkg.sv
// ---------------------------------------------------------------------------
// fs_accel_pkg
// Shared constants and helpers for the fs_accel convolution datapath.
//   FS_OBUF_DW             default output-buffer data width
//   FS_OBUF_DEPTH          default output-buffer depth (entries)
//   FS_OBUF_RELU_THRESHOLD ReLU clamp threshold; words below it are stored as 0
//   fs_clog2()             ceiling log2 usable in constant expressions
// ---------------------------------------------------------------------------
package fs_accel_pkg;

    localparam int FS_OBUF_DW             = 32;
    localparam int FS_OBUF_DEPTH          = 8;
    localparam int FS_OBUF_RELU_THRESHOLD = 0;

    // Number of bits needed to encode values 0 .. value-1; minimum result 1 so
    // that pointer declarations never collapse to zero width.
    function automatic int fs_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fs_accel_obuf_fifo_if.sv
// ---------------------------------------------------------------------------
// fs_accel_obuf_fifo_if
// Handshake bundle for the fs_accel output buffer.
//   enb            global enable (stall when low)
//   obuf_flush     synchronous clear of contents and overflow flag
//   obuf_di        load data (signed)
//   obuf_ld_valid  producer word valid
//   obuf_ld_ready  FIFO can accept a word
//   obuf_do        head-of-FIFO data
//   obuf_rd_valid  head word valid
//   obuf_rd_ready  consumer takes head word
//   obuf_count     stored-word count
//   obuf_ovf       sticky overflow flag
// Modports: master = producer/consumer side, slave = the FIFO.
// ---------------------------------------------------------------------------
interface fs_accel_obuf_fifo_if
    import fs_accel_pkg::*;
#(
    parameter int DW    = FS_OBUF_DW,
    parameter int DEPTH = FS_OBUF_DEPTH
) ();

    localparam int CW = fs_clog2(DEPTH + 1);

    logic          enb;
    logic          obuf_flush;
    logic [DW-1:0] obuf_di;
    logic          obuf_ld_valid;
    logic          obuf_ld_ready;
    logic [DW-1:0] obuf_do;
    logic          obuf_rd_valid;
    logic          obuf_rd_ready;
    logic [CW-1:0] obuf_count;
    logic          obuf_ovf;

    modport master (
        output enb,
        output obuf_flush,
        output obuf_di,
        output obuf_ld_valid,
        input  obuf_ld_ready,
        input  obuf_do,
        input  obuf_rd_valid,
        output obuf_rd_ready,
        input  obuf_count,
        input  obuf_ovf
    );

    modport slave (
        input  enb,
        input  obuf_flush,
        input  obuf_di,
        input  obuf_ld_valid,
        output obuf_ld_ready,
        output obuf_do,
        output obuf_rd_valid,
        input  obuf_rd_ready,
        output obuf_count,
        output obuf_ovf
    );

endinterface

// File: rtl/fs_accel_obuf_mem.sv
// ---------------------------------------------------------------------------
// fs_accel_obuf_mem
// DEPTH x DW register array, one synchronous write port and one asynchronous
// read port. Contents are deliberately not reset.
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
// ---------------------------------------------------------------------------
module fs_accel_obuf_mem
    import fs_accel_pkg::*;
#(
    parameter int DW    = FS_OBUF_DW,
    parameter int DEPTH = FS_OBUF_DEPTH,
    parameter int AW    = fs_clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fs_accel_obuf_fifo.sv
// ---------------------------------------------------------------------------
// fs_accel_obuf_fifo
// First-word-fall-through output buffer between the accumulator/quantiser
// stage (producer) and the bus/writeback stage (consumer).
//   clk    clock, all state changes on the rising edge
//   reset  synchronous active-high reset
//   bus    fs_accel_obuf_fifo_if.slave handshake bundle (enable, flush,
//          load/read handshakes, occupancy count, sticky overflow)
// Configuration macro: FS_ACCEL_OBUF_RELU_EN -- when defined, negative words
// are stored as zero (ReLU on load); otherwise words are stored unmodified.
// DW/DEPTH must match the parameters of the connected interface instance.
// ---------------------------------------------------------------------------
module fs_accel_obuf_fifo
    import fs_accel_pkg::*;
#(
    parameter int DW    = FS_OBUF_DW,
    parameter int DEPTH = FS_OBUF_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    fs_accel_obuf_fifo_if.slave  bus
);

    localparam int CW = fs_clog2(DEPTH + 1);
    localparam int AW = fs_clog2(DEPTH);

    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] count;
    logic          ovf;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          mem_we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Ready depends only on enable and fullness, never on the consumer, so
    // there is no combinational path from rd_ready back to ld_ready.
    assign bus.obuf_ld_ready = bus.enb & ~full;
    assign bus.obuf_rd_valid = bus.enb & ~empty;

    assign push = bus.obuf_ld_valid & bus.obuf_ld_ready;
    assign pop  = bus.obuf_rd_valid & bus.obuf_rd_ready;

    // Reset and flush take priority over a push in the same cycle, so the
    // array must not be written then either.
    assign mem_we = push & ~reset & ~bus.obuf_flush;

`ifdef FS_ACCEL_OBUF_RELU_EN
    // The sign bit alone decides the clamp, since the threshold is zero.
    assign wdata = bus.obuf_di[DW-1] ? '0 : bus.obuf_di;
`else
    assign wdata = bus.obuf_di;
`endif

    // Pointer, count and overflow update: reset, then flush, then stall on
    // enb low, then the push/pop handshake.
    always_ff @(posedge clk) begin
        if (reset || bus.obuf_flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (bus.enb) begin
            if (push) begin
                wp <= wp + AW'(1);
            end
            if (pop) begin
                rp <= rp + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            // A load attempt against a full buffer is dropped but remembered.
            if (bus.obuf_ld_valid && full) begin
                ovf <= 1'b1;
            end
        end
    end

    fs_accel_obuf_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wp),
        .wdata (wdata),
        .raddr (rp),
        .rdata (rdata)
    );

    assign bus.obuf_do    = rdata;
    assign bus.obuf_count = count;
    assign bus.obuf_ovf   = ovf;

endmodule

// File: tb/tb_fs_accel_obuf_fifo.sv
// ---------------------------------------------------------------------------
// tb_fs_accel_obuf_fifo
// Self-checking bench for fs_accel_obuf_fifo. Directed scenarios (fill,
// overflow, wrap with simultaneous push/pop, enable stall, flush, ReLU
// values) followed by randomized traffic, all checked against a queue-based
// reference model of the buffer contents.
// ---------------------------------------------------------------------------
module tb_fs_accel_obuf_fifo;
    import fs_accel_pkg::*;

    localparam int DW    = FS_OBUF_DW;
    localparam int DEPTH = FS_OBUF_DEPTH;

    logic clk;
    logic reset;

    fs_accel_obuf_fifo_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    fs_accel_obuf_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;
    logic [DW-1:0] model_q[$];
    bit            model_ovf = 1'b0;

    // Value the buffer is expected to hold for a loaded word.
    function automatic logic [DW-1:0] stored_value(input logic [DW-1:0] d);
`ifdef FS_ACCEL_OBUF_RELU_EN
        if ($signed(d) < 0) begin
            return '0;
        end
        return d;
`else
        return d;
`endif
    endfunction

    task automatic check_output(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs shortly after the rising edge.
    task automatic apply_stimulus(input bit e, input bit ldv,
                                  input logic [DW-1:0] di, input bit rdr,
                                  input bit fl, input bit rst);
        @(posedge clk);
        #1;
        bus.enb           = e;
        bus.obuf_ld_valid = ldv;
        bus.obuf_di       = di;
        bus.obuf_rd_ready = rdr;
        bus.obuf_flush    = fl;
        reset             = rst;
    endtask

    // Monitor: on the falling edge compare every output against the model,
    // then advance the model by what the coming rising edge will do.
    always @(negedge clk) begin
        if (mon_en) begin
            bit mfull;
            bit mempty;
            mfull  = (model_q.size() == DEPTH);
            mempty = (model_q.size() == 0);
            check_output("count", 64'(bus.obuf_count), 64'(model_q.size()));
            check_output("ovf", 64'(bus.obuf_ovf), 64'(model_ovf));
            check_output("ld_ready", 64'(bus.obuf_ld_ready),
                         64'(bus.enb && !mfull));
            check_output("rd_valid", 64'(bus.obuf_rd_valid),
                         64'(bus.enb && !mempty));
            if (bus.enb && !mempty) begin
                check_output("head_data", 64'(bus.obuf_do), 64'(model_q[0]));
            end

            if (reset || bus.obuf_flush) begin
                model_q.delete();
                model_ovf = 1'b0;
            end else if (bus.enb) begin
                if (bus.obuf_ld_valid && mfull) begin
                    model_ovf = 1'b1;
                end
                if (bus.obuf_rd_ready && !mempty) begin
                    void'(model_q.pop_front());
                end
                if (bus.obuf_ld_valid && !mfull) begin
                    model_q.push_back(stored_value(bus.obuf_di));
                end
            end
        end
    end

    initial begin
        reset             = 1'b1;
        bus.enb           = 1'b1;
        bus.obuf_flush    = 1'b0;
        bus.obuf_di       = '0;
        bus.obuf_ld_valid = 1'b0;
        bus.obuf_rd_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        $display("[TB] reset released, starting directed scenarios");

        // Fill with 0x11..0x88, consumer idle.
        for (int k = 1; k <= DEPTH; k++) begin
            apply_stimulus(1, 1, DW'(k * 32'h11), 0, 0, 0);
        end
        // Overflow attempt while full.
        apply_stimulus(1, 1, DW'(32'hDEAD), 0, 0, 0);
        apply_stimulus(1, 0, '0, 0, 0, 0);
        // Drain everything.
        for (int k = 0; k < DEPTH; k++) begin
            apply_stimulus(1, 0, '0, 1, 0, 0);
        end

        // Move both pointers to 6, then load 3 words so wp wraps to 1.
        for (int k = 0; k < 6; k++) apply_stimulus(1, 1, DW'(32'h100 + k), 0, 0, 0);
        for (int k = 0; k < 6; k++) apply_stimulus(1, 0, '0, 1, 0, 0);
        for (int k = 0; k < 3; k++) apply_stimulus(1, 1, DW'(32'h200 + k), 0, 0, 0);
        // Simultaneous push and pop across the wrap.
        for (int k = 0; k < 6; k++) apply_stimulus(1, 1, DW'(32'h300 + k), 1, 0, 0);
        // Down to 2 words, then stall with both handshakes requested.
        apply_stimulus(1, 0, '0, 1, 0, 0);
        for (int k = 0; k < 4; k++) apply_stimulus(0, 1, DW'(32'hBAD0 + k), 1, 0, 0);
        apply_stimulus(1, 0, '0, 0, 0, 0);

        // Build up to 5 words, overflow again, then flush alongside a push.
        for (int k = 0; k < 6; k++) apply_stimulus(1, 1, DW'(32'h400 + k), 0, 0, 0);
        apply_stimulus(1, 1, DW'(32'hDEAD), 0, 0, 0);
        apply_stimulus(1, 0, '0, 1, 0, 0);
        apply_stimulus(1, 0, '0, 1, 0, 0);
        apply_stimulus(1, 0, '0, 1, 0, 0);
        apply_stimulus(1, 1, DW'(32'h77), 1, 1, 0);
        apply_stimulus(1, 0, '0, 0, 0, 0);

        // Negative and positive load values.
        apply_stimulus(1, 1, DW'(32'hFFFF_FFF6), 0, 0, 0);
        apply_stimulus(1, 1, DW'(32'h0000_000A), 0, 0, 0);
        apply_stimulus(1, 0, '0, 1, 0, 0);
        apply_stimulus(1, 0, '0, 1, 0, 0);
        apply_stimulus(1, 0, '0, 0, 0, 0);

        // Randomized traffic in three bias phases.
        $display("[TB] starting randomized traffic");
        for (int phase = 0; phase < 3; phase++) begin
            for (int k = 0; k < 700; k++) begin
                bit e;
                bit ldv;
                bit rdr;
                e   = ($urandom_range(0, 9) != 0);
                ldv = (phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                rdr = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
                apply_stimulus(e, ldv, DW'($urandom), rdr,
                               ($urandom_range(0, 99) == 0),
                               ($urandom_range(0, 199) == 0));
            end
        end

        // Final drain.
        for (int k = 0; k < DEPTH + 2; k++) apply_stimulus(1, 0, '0, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fs_accel_obuf_fifo.md
# fs_accel_obuf_fifo

Parametrised output buffer for the fs_accel convolution datapath. It replaces the single-word output register with a DEPTH-entry first-word-fall-through FIFO and valid/ready handshakes on both sides. The FIFO sits between the accumulator/quantiser stage, which pushes results, and the bus/writeback stage, which drains them. It adds occupancy reporting, flush, a sticky overflow flag and optional ReLU on load.

## Interface
Parameters:
- DW, 32, data word width in bits; must be at least 2.
- DEPTH, 8, number of entries; power of two, at least 2.
- CW, $clog2(DEPTH+1), occupancy count width. Derived; never overridden.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enb  in  1  global enable. When low, the block is stalled: no push, no pop, no state change.
- obuf_flush  in  1  synchronous clear of contents and overflow flag.
- obuf_di  in  DW  load data, signed two's complement.
- obuf_ld_valid  in  1  producer has a word on obuf_di.
- obuf_ld_ready  out  1  FIFO accepts a word this cycle.
- obuf_do  out  DW  head-of-FIFO data.
- obuf_rd_valid  out  1  obuf_do holds a valid word.
- obuf_rd_ready  in  1  consumer takes the head word this cycle.
- obuf_count  out  CW  current number of stored words.
- obuf_ovf  out  1  sticky flag: a push was attempted while full.

## Operation
- Storage is a DEPTH x DW register array with write pointer wp and read pointer rp. Each pointer is $clog2(DEPTH) bits and wraps naturally.
- full = (count == DEPTH); empty = (count == 0).
- obuf_ld_ready = enb & ~full. It does not depend on obuf_rd_ready, so there is no combinational path from consumer to producer.
- obuf_rd_valid = enb & ~empty.
- push = obuf_ld_valid & obuf_ld_ready. It writes mem[wp] and increments wp.
- pop = obuf_rd_valid & obuf_rd_ready. It increments rp.
- Count update: +1 on push only, -1 on pop only, unchanged on push and pop together. Push and pop together is legal at any non-empty occupancy below DEPTH. When full, only a pop occurs.
- obuf_do = mem[rp] (FWFT). When obuf_rd_valid is low, obuf_do is undefined to the consumer and must not be checked.
- Overflow: if enb & obuf_ld_valid & full, obuf_ovf is set to 1 on that edge. The word is dropped and the contents are unchanged.
- Update priority per edge: reset, then obuf_flush, then (enb low: hold everything), then push/pop.
- obuf_flush clears wp, rp, count and obuf_ovf, regardless of enb. Any push or pop presented in the same cycle is ignored.
- Memory contents are not reset; only pointers, count and flag are.

## Timing
- Reset values: obuf_count = 0, obuf_ovf = 0, obuf_rd_valid = 0, obuf_ld_ready = enb. Pointers are 0.
- Write-to-read latency is 1 cycle. A word pushed at edge N appears on obuf_do with obuf_rd_valid high after edge N, if the FIFO was empty.
- obuf_count reflects all pushes and pops up to the previous edge. It is registered, not a lookahead.
- Reset or flush in the middle of a burst takes effect at that edge. From the next cycle the FIFO is empty and obuf_ld_ready equals enb.
- Deasserting enb masks the handshake outputs in the same cycle (they are combinational from enb). Contents and pointers are preserved. Reasserting enb resumes with the same head word.

## Configuration
- Macro: FS_ACCEL_OBUF_RELU_EN.
- Defined: on push, the stored word is 0 when obuf_di[DW-1] is 1; otherwise it is obuf_di. ReLU is applied before storage, so the read side adds no latency.
- Undefined: obuf_di is stored unmodified.
- The macro has no effect on the handshake, count or timing.

## Structure
- Shared package fs_accel_pkg holds:
  - the default constants FS_OBUF_DW = 32 and FS_OBUF_DEPTH = 8;
  - a clog2 helper for CW and pointer widths;
  - the enum or constant for the default ReLU threshold (0).
- Sub-module fs_accel_obuf_mem: the DW x DEPTH register array with one write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
- fs_accel_obuf_fifo holds the pointers, count, flag and handshake logic, plus the ReLU mux under the macro.

## Test plan
- Reset then fill: push 0x11, 0x22, ..., 0x88 with rd_ready = 0. Required: count goes 1..8; ld_ready = 0 after the eighth push; rd_valid = 1 with do = 0x11.
- Overflow: when full, hold ld_valid = 1 with di = 0xDEAD for 1 cycle. Required: obuf_ovf = 1, count = 8, and draining returns 0x11..0x88 in order with 0xDEAD absent.
- Simultaneous push and pop at count = 3, with pointers wrapped (wp = 1, rp = 6). Required: count stays 3 and order is preserved across the wrap.
- enb stall: at count = 2, drop enb for 4 cycles with ld_valid = rd_ready = 1. Required: rd_valid = ld_ready = 0 and count = 2 throughout; the same head word appears after enb returns.
- Flush with push at count = 5 and ovf = 1. Required: next cycle count = 0, ovf = 0, rd_valid = 0, and the pushed word is not stored.
- With FS_ACCEL_OBUF_RELU_EN defined, push 0xFFFFFFF6 then 0x0000000A. Required: read 0x00000000 then 0x0000000A. Without the macro, read 0xFFFFFFF6 then 0x0000000A.
